// File: rtl/t2mi_packet_scheduler.sv
// T2-MI packet scheduler: orders BB-frame / timestamp / L1 packets per T2 frame and
// supplies per-packet header fields to the packetizer, one command per packet.
module t2mi_packet_scheduler #(
  parameter int unsigned DONE_TIMEOUT = 16384
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [9:0]  plp_num_blocks,
  input  logic [7:0]  num_t2_frames,
  input  logic [26:0] T_sf_ssu,
  output logic        CMD_VALID,
  input  logic        CMD_READY,
  output logic [1:0]  CMD_TYPE,
  output logic [7:0]  CMD_PKT_COUNT,
  output logic [3:0]  CMD_SF_IDX,
  output logic [7:0]  CMD_FRAME_IDX,
  output logic        CMD_INTL_START,
  output logic [26:0] CMD_SUBSEC,
  input  logic        PKT_DONE,
  output logic        CFG_ERR,
  output logic        TIMEOUT_ERR,
  output logic [1:0]  state_mon
);

  localparam int unsigned BLK_W = 10;
  localparam int unsigned NFT_W = 8;
  localparam int unsigned SS_W  = 27;
  localparam int unsigned WD_W  = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_ADVANCE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    T_BB = 2'd0,
    T_TS = 2'd1,
    T_L1 = 2'd2
  } pkt_type_e;

  state_e            state_q, state_d;
  pkt_type_e         type_q, type_d;
  logic [BLK_W-1:0]  bb_idx_q, bb_idx_d;
  logic [BLK_W-1:0]  nblk_q, nblk_d;
  logic [NFT_W-1:0]  nft_q, nft_d;
  logic [7:0]        pkt_cnt_q, pkt_cnt_d;
  logic [3:0]        sf_idx_q, sf_idx_d;
  logic [7:0]        frame_idx_q, frame_idx_d;
  logic [SS_W-1:0]   subsec_q, subsec_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              frame_start_q, frame_start_d;
  logic              valid_q, valid_d;
  logic              intl_q, intl_d;
  logic              cfg_err_q, cfg_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic              latch_cfg;

  // State and field registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      type_q        <= T_BB;
      bb_idx_q      <= '0;
      nblk_q        <= '0;
      nft_q         <= NFT_W'(1);
      pkt_cnt_q     <= '0;
      sf_idx_q      <= '0;
      frame_idx_q   <= '0;
      subsec_q      <= '0;
      wd_q          <= '0;
      frame_start_q <= 1'b1;
      valid_q       <= 1'b0;
      intl_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      bb_idx_q      <= bb_idx_d;
      nblk_q        <= nblk_d;
      nft_q         <= nft_d;
      pkt_cnt_q     <= pkt_cnt_d;
      sf_idx_q      <= sf_idx_d;
      frame_idx_q   <= frame_idx_d;
      subsec_q      <= subsec_d;
      wd_q          <= wd_d;
      frame_start_q <= frame_start_d;
      valid_q       <= valid_d;
      intl_q        <= intl_d;
      cfg_err_q     <= cfg_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state, packet sequencing and frame/superframe counters
  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    bb_idx_d      = bb_idx_q;
    nblk_d        = nblk_q;
    nft_d         = nft_q;
    pkt_cnt_d     = pkt_cnt_q;
    sf_idx_d      = sf_idx_q;
    frame_idx_d   = frame_idx_q;
    subsec_d      = subsec_q;
    wd_d          = wd_q;
    frame_start_d = frame_start_q;
    cfg_err_d     = cfg_err_q;
    timeout_err_d = timeout_err_q;
    latch_cfg     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ENABLE) begin
          state_d   = S_ISSUE;
          latch_cfg = frame_start_q;
        end
      end
      S_ISSUE: begin
        if (CMD_READY) begin
          state_d       = S_WAIT_DONE;
          wd_d          = '0;
          frame_start_d = 1'b0;
        end
      end
      S_WAIT_DONE: begin
        if (PKT_DONE) begin
          state_d = S_ADVANCE;
        end else if (DONE_TIMEOUT != 0) begin
          if (wd_q == WD_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = S_ADVANCE;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end
      default: begin
        pkt_cnt_d = pkt_cnt_q + 8'd1;
        state_d   = ENABLE ? S_ISSUE : S_IDLE;
        case (type_q)
          T_BB: begin
            bb_idx_d = bb_idx_q + BLK_W'(1);
            if (bb_idx_q + BLK_W'(1) == nblk_q) type_d = T_TS;
          end
          T_TS: type_d = T_L1;
          default: begin
            bb_idx_d      = '0;
            frame_start_d = 1'b1;
            latch_cfg     = 1'b1;
            // >= keeps the frame index bounded if the frame count shrinks at relatch
            if (frame_idx_q >= nft_q - NFT_W'(1)) begin
              frame_idx_d = '0;
              sf_idx_d    = sf_idx_q + 4'd1;
              subsec_d    = subsec_q + T_sf_ssu;
            end else begin
              frame_idx_d = frame_idx_q + 8'd1;
            end
          end
        endcase
      end
    endcase

    // Config is only sampled at a frame boundary; it also picks the frame's first packet type
    if (latch_cfg) begin
      nblk_d = plp_num_blocks;
      nft_d  = (num_t2_frames == '0) ? NFT_W'(1) : num_t2_frames;
      if (plp_num_blocks == '0) begin
        type_d    = T_TS;
        cfg_err_d = 1'b1;
      end else begin
        type_d = T_BB;
      end
    end
  end

  // Registered command outputs
  always_comb begin
    valid_d = (state_d == S_ISSUE);
    intl_d  = intl_q;
    if (latch_cfg || (state_q == S_ADVANCE)) begin
      intl_d = (type_d == T_BB) && (bb_idx_d == '0);
    end
  end

  assign CMD_VALID      = valid_q;
  assign CMD_TYPE       = type_q;
  assign CMD_PKT_COUNT  = pkt_cnt_q;
  assign CMD_SF_IDX     = sf_idx_q;
  assign CMD_FRAME_IDX  = frame_idx_q;
  assign CMD_INTL_START = intl_q;
  assign CMD_SUBSEC     = subsec_q;
  assign CFG_ERR        = cfg_err_q;
  assign TIMEOUT_ERR    = timeout_err_q;
  assign state_mon      = state_q;

endmodule

// File: tb/tb_t2mi_packet_scheduler.sv
// Bench for t2mi_packet_scheduler: directed scenarios plus randomized segments, checked
// against a closed-form model of the packet sequence (packet n -> frame, position, superframe).
module tb_t2mi_packet_scheduler;

  localparam int unsigned DONE_TIMEOUT = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENABLE;
  logic [9:0]  plp_num_blocks;
  logic [7:0]  num_t2_frames;
  logic [26:0] T_sf_ssu;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_TYPE;
  logic [7:0]  CMD_PKT_COUNT;
  logic [3:0]  CMD_SF_IDX;
  logic [7:0]  CMD_FRAME_IDX;
  logic        CMD_INTL_START;
  logic [26:0] CMD_SUBSEC;
  logic        PKT_DONE;
  logic        CFG_ERR;
  logic        TIMEOUT_ERR;
  logic [1:0]  state_mon;

  t2mi_packet_scheduler #(.DONE_TIMEOUT(DONE_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
    .plp_num_blocks(plp_num_blocks), .num_t2_frames(num_t2_frames), .T_sf_ssu(T_sf_ssu),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TYPE(CMD_TYPE),
    .CMD_PKT_COUNT(CMD_PKT_COUNT), .CMD_SF_IDX(CMD_SF_IDX), .CMD_FRAME_IDX(CMD_FRAME_IDX),
    .CMD_INTL_START(CMD_INTL_START), .CMD_SUBSEC(CMD_SUBSEC), .PKT_DONE(PKT_DONE),
    .CFG_ERR(CFG_ERR), .TIMEOUT_ERR(TIMEOUT_ERR), .state_mon(state_mon)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: packet index since reset and the fixed configuration of the segment
  int unsigned n;
  int unsigned m_nblk;
  int unsigned m_nft;
  logic [26:0] m_t;
  logic        m_to;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (pkt %0d)", tag, obs, exp, n);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_fields(input string tag);
    int unsigned p   = (m_nblk == 0) ? 2 : m_nblk + 2;
    int unsigned f   = n / p;
    int unsigned pos = n % p;
    int unsigned s   = f / m_nft;
    int unsigned ty  = (pos < m_nblk) ? 0 : ((pos == m_nblk) ? 1 : 2);
    logic [63:0] ss  = (64'(s) * 64'(m_t)) % (64'd1 << 27);
    check({tag, ".type"},  64'(CMD_TYPE),       64'(ty));
    check({tag, ".count"}, 64'(CMD_PKT_COUNT),  64'(n % 256));
    check({tag, ".frame"}, 64'(CMD_FRAME_IDX),  64'(f % m_nft));
    check({tag, ".sf"},    64'(CMD_SF_IDX),     64'(s % 16));
    check({tag, ".intl"},  64'(CMD_INTL_START), 64'(ty == 0 && pos == 0));
    check({tag, ".subsec"}, 64'(CMD_SUBSEC),    ss);
    check({tag, ".cfgerr"}, 64'(CFG_ERR),       64'(m_nblk == 0));
    check({tag, ".toerr"}, 64'(TIMEOUT_ERR),    64'(m_to));
  endtask

  task automatic do_reset(input int unsigned nblk, input int unsigned nft, input logic [26:0] t);
    ENABLE = 1'b0; CMD_READY = 1'b0; PKT_DONE = 1'b0;
    RST = 1'b0;
    #1;
    check("rst.valid", 64'(CMD_VALID), 64'd0);
    check("rst.count", 64'(CMD_PKT_COUNT), 64'd0);
    check("rst.state", 64'(state_mon), 64'd0);
    check("rst.errs",  64'({CFG_ERR, TIMEOUT_ERR}), 64'd0);
    check("rst.fields", 64'({CMD_TYPE, CMD_SF_IDX, CMD_FRAME_IDX, CMD_INTL_START, CMD_SUBSEC}), 64'd0);
    plp_num_blocks = 10'(nblk);
    num_t2_frames  = 8'(nft);
    T_sf_ssu       = t;
    tick();
    RST = 1'b1;
    tick();
    n = 0; m_nblk = nblk; m_nft = (nft == 0) ? 1 : nft; m_t = t; m_to = 1'b0;
    ENABLE = 1'b1;
  endtask

  // Wait for a command, optionally stall READY, accept, complete after done_dly cycles
  task automatic wait_valid();
    int k = 0;
    tick();
    k++;
    while (!CMD_VALID && k < 40) begin
      tick();
      k++;
    end
    check("gap", 64'(k), 64'd1);
    check("issue.state", 64'(state_mon), 64'd1);
    check_fields("issue");
  endtask

  task automatic accept();
    CMD_READY = 1'b1;
    tick();
    CMD_READY = 1'b0;
    check("acc.valid", 64'(CMD_VALID), 64'd0);
    check("acc.state", 64'(state_mon), 64'd2);
  endtask

  task automatic run_packet(input int hold, input int done_dly, input bit drop_en, input int idle_cyc);
    wait_valid();
    for (int i = 0; i < hold; i++) begin
      PKT_DONE = (i == 0);
      tick();
      PKT_DONE = 1'b0;
      check("hold.valid", 64'(CMD_VALID), 64'd1);
      check_fields("hold");
    end
    accept();
    if (drop_en) ENABLE = 1'b0;
    repeat (done_dly - 1) tick();
    PKT_DONE = 1'b1;
    tick();
    PKT_DONE = 1'b0;
    check("adv.state", 64'(state_mon), 64'd3);
    n++;
    if (drop_en) begin
      tick();
      check("drop.state", 64'(state_mon), 64'd0);
      repeat (idle_cyc) tick();
      check("drop.valid", 64'(CMD_VALID), 64'd0);
      check("drop.idle", 64'(state_mon), 64'd0);
      ENABLE = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Basic sequence: 2 blocks, 2 frames, DONE 5 cycles after accept
    do_reset(2, 2, 27'd100);
    for (int i = 0; i < 8; i++) run_packet(0, 5, 1'b0, 0);

    // Superframe index and subsecond wrap
    do_reset(1, 1, 27'h7FFFFF0);
    for (int i = 0; i < 51; i++) run_packet(0, 2, 1'b0, 0);

    // READY held low 10 cycles with a stray PKT_DONE in ISSUE
    do_reset(3, 2, 27'd5);
    run_packet(10, 3, 1'b0, 0);
    run_packet(10, 1, 1'b0, 0);

    // Zero blocks per frame: timestamp and L1 only, frames still advance
    do_reset(0, 3, 27'd77);
    for (int i = 0; i < 8; i++) run_packet(0, 3, 1'b0, 0);

    // Watchdog fires after DONE_TIMEOUT cycles without PKT_DONE
    do_reset(1, 1, 27'd9);
    wait_valid();
    accept();
    repeat (DONE_TIMEOUT - 1) tick();
    check("wd.before", 64'(TIMEOUT_ERR), 64'd0);
    check("wd.wait", 64'(state_mon), 64'd2);
    tick();
    check("wd.fired", 64'(TIMEOUT_ERR), 64'd1);
    check("wd.adv", 64'(state_mon), 64'd3);
    n++;
    m_to = 1'b1;
    run_packet(0, 4, 1'b0, 0);

    // ENABLE dropped in WAIT_DONE, resumed later
    do_reset(2, 2, 27'd33);
    run_packet(0, 2, 1'b0, 0);
    run_packet(0, 3, 1'b1, 6);
    run_packet(0, 2, 1'b1, 3);
    run_packet(0, 2, 1'b0, 0);
    run_packet(0, 2, 1'b0, 0);

    // Randomized segments
    for (int seg = 0; seg < 6; seg++) begin
      do_reset($urandom_range(0, 3), $urandom_range(0, 3), 27'($urandom));
      for (int i = 0; i < 14; i++) begin
        run_packet($urandom_range(0, 2), $urandom_range(1, 7),
                   ($urandom_range(0, 5) == 0), $urandom_range(0, 4));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
